// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side bus of the cache/RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the
// view of the caches plus the RAM.
interface cache_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between the icache and the dcache.
// The dcache wins contested arbitrations until it has won STARVE_MAX of
// them in a row. The next contested arbitration then goes to the icache.
// The grant is held for the whole RAM transaction. Every access is
// followed by one IDLE cycle.
module cache_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic           CLK,
  input logic           nRST,
  cache_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, IGRANT = 2'd1, DGRANT = 2'd2} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [3:0] SMAX      = STARVE_MAX[3:0];

  state_t      r_state, w_next;
  logic [3:0]  r_starve, w_starve_nx;
  logic        w_dreq;
  logic        w_iwait, w_dwait, w_ren, w_wen;
  logic [31:0] w_iload, w_dload, w_addr, w_store;

  assign w_dreq = bus.dREN | bus.dWEN;

  // State register and starvation counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_next;
      r_starve <= w_starve_nx;
    end
  end

  // Arbitration, RAM strobes and wait/load responses
  always_comb begin
    w_next      = r_state;
    w_starve_nx = r_starve;
    w_iwait     = 1'b1;
    w_dwait     = 1'b1;
    w_iload     = '0;
    w_dload     = '0;
    w_ren       = 1'b0;
    w_wen       = 1'b0;
    w_addr      = '0;
    w_store     = '0;
    case (r_state)
      IDLE: begin
        if (w_dreq && bus.iREN) begin
          if (r_starve < SMAX) begin
            w_next      = DGRANT;
            w_starve_nx = r_starve + 4'd1;
          end else begin
            w_next      = IGRANT;
            w_starve_nx = '0;
          end
        end else if (w_dreq) begin
          w_next = DGRANT;
        end else if (bus.iREN) begin
          w_next      = IGRANT;
          w_starve_nx = '0;
        end
      end
      IGRANT: begin
        if (!bus.iREN) begin
          // The request was withdrawn, so no strobe and no wait pulse.
          w_next = IDLE;
        end else begin
          w_ren  = 1'b1;
          w_addr = bus.iaddr;
          if (bus.ramstate == RS_ACCESS) begin
            w_iwait = 1'b0;
            w_iload = bus.ramload;
            w_next  = IDLE;
          end else if (bus.ramstate == RS_ERROR) begin
            // The request is still held, so it is retried through IDLE.
            w_next = IDLE;
          end
        end
      end
      DGRANT: begin
        if (!w_dreq) begin
          w_next = IDLE;
        end else begin
          // When dREN and dWEN are both high, the access is a write.
          w_wen   = bus.dWEN;
          w_ren   = ~bus.dWEN;
          w_addr  = bus.daddr;
          w_store = bus.dWEN ? bus.dstore : '0;
          if (bus.ramstate == RS_ACCESS) begin
            w_dwait = 1'b0;
            w_dload = bus.dWEN ? '0 : bus.ramload;
            w_next  = IDLE;
          end else if (bus.ramstate == RS_ERROR) begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.iwait    = w_iwait;
  assign bus.dwait    = w_dwait;
  assign bus.iload    = w_iload;
  assign bus.dload    = w_dload;
  assign bus.ramREN   = w_ren;
  assign bus.ramWEN   = w_wen;
  assign bus.ramaddr  = w_addr;
  assign bus.ramstore = w_store;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with STARVE_MAX=4.
// Inputs are driven 2 time units after the rising edge. Outputs are
// checked 1 time unit later, well away from both clock edges.
module tb_cache_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  cache_mem_arbiter_if bus();

  cache_mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = 2'd0;
  endtask

  initial begin
    logic pat [10];
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    nRST = 0;
    #3;
    chk("rst_iwait", 32'(bus.iwait), 1);
    chk("rst_dwait", 32'(bus.dwait), 1);
    chk("rst_ren", 32'(bus.ramREN), 0);
    chk("rst_wen", 32'(bus.ramWEN), 0);
    chk("rst_addr", bus.ramaddr, 0);
    chk("rst_starve", 32'(dut.r_starve), 0);
    cyc(); nRST = 1;

    // Lone icache read
    cyc(); bus.iREN = 1; bus.iaddr = 32'h100; #1;
    chk("i_c0_ren", 32'(bus.ramREN), 0);
    cyc(); bus.ramstate = 2'd1; #1;
    chk("i_c1_ren", 32'(bus.ramREN), 1);
    chk("i_c1_addr", bus.ramaddr, 32'h100);
    chk("i_c1_iwait", 32'(bus.iwait), 1);
    cyc(); bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF; #1;
    chk("i_c2_iwait", 32'(bus.iwait), 0);
    chk("i_c2_iload", bus.iload, 32'hDEADBEEF);
    chk("i_c2_dwait", 32'(bus.dwait), 1);
    cyc(); idle_inputs(); #1;
    chk("i_c3_iwait", 32'(bus.iwait), 1);
    chk("i_c3_iload", bus.iload, 0);
    chk("i_c3_ren", 32'(bus.ramREN), 0);

    // Dcache write with dREN and dWEN both high
    cyc(); bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678; #1;
    chk("w_c0_wen", 32'(bus.ramWEN), 0);
    cyc(); bus.ramstate = 2'd1; #1;
    chk("w_c1_wen", 32'(bus.ramWEN), 1);
    chk("w_c1_ren", 32'(bus.ramREN), 0);
    chk("w_c1_addr", bus.ramaddr, 32'h200);
    chk("w_c1_store", bus.ramstore, 32'h12345678);
    chk("w_c1_dwait", 32'(bus.dwait), 1);
    cyc(); #1;
    chk("w_c2_wen", 32'(bus.ramWEN), 1);
    chk("w_c2_dwait", 32'(bus.dwait), 1);
    cyc(); bus.ramstate = 2'd2; bus.ramload = 32'hAAAA5555; #1;
    chk("w_c3_dwait", 32'(bus.dwait), 0);
    chk("w_c3_dload", bus.dload, 0);
    cyc(); idle_inputs(); #1;
    chk("w_c4_dwait", 32'(bus.dwait), 1);
    chk("w_c4_wen", 32'(bus.ramWEN), 0);
    chk("w_starve", 32'(dut.r_starve), 0);

    // Contention: expected grants D,D,D,D,I,D,D,D,D,I
    cyc(); bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h300; bus.daddr = 32'h400;
    for (int k = 0; k < 10; k++) begin
      bus.ramstate = 2'd0; #1;
      chk($sformatf("c%0d_idle_ren", k), 32'(bus.ramREN), 0);
      cyc(); bus.ramstate = 2'd2; bus.ramload = 32'h1000 + 32'(k); #1;
      chk($sformatf("c%0d_ren", k), 32'(bus.ramREN), 1);
      chk($sformatf("c%0d_addr", k), bus.ramaddr, pat[k] ? 32'h300 : 32'h400);
      chk($sformatf("c%0d_iwait", k), 32'(bus.iwait), pat[k] ? 32'd0 : 32'd1);
      chk($sformatf("c%0d_dwait", k), 32'(bus.dwait), pat[k] ? 32'd1 : 32'd0);
      if (k == 3) chk("c3_starve", 32'(dut.r_starve), 4);
      cyc();
    end
    chk("c_end_starve", 32'(dut.r_starve), 0);
    idle_inputs();

    // ERROR retry
    cyc(); bus.dREN = 1; bus.daddr = 32'h40; #1;
    cyc(); bus.ramstate = 2'd3; #1;
    chk("e_c1_ren", 32'(bus.ramREN), 1);
    chk("e_c1_dwait", 32'(bus.dwait), 1);
    cyc(); bus.ramstate = 2'd0; #1;
    chk("e_c2_ren", 32'(bus.ramREN), 0);
    chk("e_c2_dwait", 32'(bus.dwait), 1);
    cyc(); bus.ramstate = 2'd2; bus.ramload = 32'h0BADF00D; #1;
    chk("e_c3_addr", bus.ramaddr, 32'h40);
    chk("e_c3_dwait", 32'(bus.dwait), 0);
    chk("e_c3_dload", bus.dload, 32'h0BADF00D);
    cyc(); idle_inputs(); #1;
    chk("e_c4_dwait", 32'(bus.dwait), 1);

    // Request withdrawn in IGRANT
    cyc(); bus.iREN = 1; bus.iaddr = 32'h500; #1;
    cyc(); bus.ramstate = 2'd1; #1;
    chk("x_c1_ren", 32'(bus.ramREN), 1);
    bus.iREN = 0; #1;
    chk("x_c1_drop_ren", 32'(bus.ramREN), 0);
    chk("x_c1_iwait", 32'(bus.iwait), 1);
    cyc(); bus.ramstate = 2'd2; #1;
    chk("x_c2_state", 32'(dut.r_state), 0);
    chk("x_c2_iwait", 32'(bus.iwait), 1);
    idle_inputs();

    // Async reset in the middle of a contested DGRANT
    cyc(); bus.iREN = 1; bus.dWEN = 1; bus.daddr = 32'h600; bus.dstore = 32'h77; #1;
    cyc(); bus.ramstate = 2'd1; #1;
    chk("r_c1_wen", 32'(bus.ramWEN), 1);
    chk("r_c1_starve", 32'(dut.r_starve), 1);
    nRST = 0; #1;
    chk("r_wen", 32'(bus.ramWEN), 0);
    chk("r_ren", 32'(bus.ramREN), 0);
    chk("r_iwait", 32'(bus.iwait), 1);
    chk("r_dwait", 32'(bus.dwait), 1);
    chk("r_state", 32'(dut.r_state), 0);
    chk("r_starve", 32'(dut.r_starve), 0);
    idle_inputs();
    cyc(); nRST = 1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
